// File: rtl/pe_inject_arbiter_pkg.sv
// Shared NOC parameters and arbiter state encoding for the PE injection arbiter.
package pe_inject_arbiter_pkg;

  localparam int unsigned NOC_DATA_WIDTH = 8;
  localparam int unsigned NOC_VICH_ADDR  = 1;
  localparam int unsigned SKID_DEPTH     = 2;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/pe_inject_arbiter_skid.sv
// Two-entry flit+VC FIFO between the arbiter and the NOC PE port.
module pe_inj_skid
  import pe_inject_arbiter_pkg::*;
#(
  parameter int unsigned DataWidth = NOC_DATA_WIDTH,
  parameter int unsigned ViChAddr  = NOC_VICH_ADDR
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic [ViChAddr-1:0]  sel_i,
  input  logic                 pop_i,
  output logic                 in_ready_o,
  output logic                 valid_o,
  output logic [DataWidth-1:0] data_o,
  output logic [ViChAddr-1:0]  sel_o
);

  logic [DataWidth+ViChAddr-1:0] mem_q [SKID_DEPTH];
  logic                          wr_ptr_q, rd_ptr_q;
  logic [1:0]                    count_q, count_d;
  logic                          do_push, do_pop;

  assign in_ready_o = (count_q < 2'(SKID_DEPTH));
  assign valid_o    = (count_q != '0);
  assign do_push    = push_i && in_ready_o;
  assign do_pop     = valid_o && pop_i;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= {data_i, sel_i};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign {data_o, sel_o} = mem_q[rd_ptr_q];

endmodule

// File: rtl/pe_inject_arbiter.sv
// Packet-atomic round-robin arbiter sharing one NOC PE injection port among NumReq sources.
module pe_inject_arbiter
  import pe_inject_arbiter_pkg::*;
#(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned DataWidth = NOC_DATA_WIDTH,
  parameter int unsigned ViChAddr  = NOC_VICH_ADDR,
  parameter int unsigned MaxFlits  = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NumReq-1:0]             req_valid,
  input  logic [NumReq*DataWidth-1:0]   req_data,
  input  logic [NumReq-1:0]             req_last,
  input  logic [NumReq*ViChAddr-1:0]    req_vc,
  output logic [NumReq-1:0]             req_ready,
  output logic [DataWidth-1:0]          PE_OutpData,
  output logic                          PE_OutpEn,
  input  logic                          PE_OutpReady,
  output logic [ViChAddr-1:0]           PE_OutpSel,
  output logic                          pkt_done,
  output logic [$clog2(NumReq)-1:0]     pkt_src,
  output logic                          len_err
);

  localparam int unsigned GrantW = $clog2(NumReq);
  localparam int unsigned CntW   = $clog2(MaxFlits + 1);

  arb_state_e          state_q, state_d;
  logic [GrantW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GrantW-1:0]   grant_q, grant_d;
  logic [CntW-1:0]     flit_cnt_q, flit_cnt_d;
  logic [ViChAddr-1:0] vc_latched_q, vc_latched_d;
  logic                len_err_q, len_err_d;

  logic [DataWidth-1:0] data_arr [NumReq];
  logic [ViChAddr-1:0]  vc_arr   [NumReq];
  logic [GrantW-1:0]    winner, cand;
  logic                 win_found;
  int unsigned          idx;
  logic                 skid_in_ready, push;
  logic [ViChAddr-1:0]  push_sel;

  for (genvar i = 0; i < NumReq; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DataWidth +: DataWidth];
    assign vc_arr[i]   = req_vc[i*ViChAddr +: ViChAddr];
  end

  // First valid requester searching upward from rr_ptr, wrapping at NumReq.
  always_comb begin
    winner    = '0;
    cand      = '0;
    idx       = 0;
    win_found = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx  = (32'(rr_ptr_q) + k) % NumReq;
      cand = GrantW'(idx);
      if (!win_found && req_valid[cand]) begin
        winner    = cand;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    flit_cnt_d   = flit_cnt_q;
    vc_latched_d = vc_latched_q;
    len_err_d    = len_err_q;
    req_ready    = '0;
    push         = 1'b0;
    pkt_done     = 1'b0;
    push_sel     = (flit_cnt_q == '0) ? vc_arr[grant_q] : vc_latched_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d    = winner;
          rr_ptr_d   = (winner == GrantW'(NumReq - 1)) ? '0 : winner + 1'b1;
          flit_cnt_d = '0;
          state_d    = LOCK;
        end
      end
      LOCK: begin
        req_ready[grant_q] = skid_in_ready;
        push               = req_valid[grant_q] && skid_in_ready;
        if (push) begin
          flit_cnt_d = flit_cnt_q + 1'b1;
          if (flit_cnt_q == '0) begin
            vc_latched_d = vc_arr[grant_q];
          end
          // A packet reaching MaxFlits without a last marker is force-closed.
          if (req_last[grant_q] || (flit_cnt_q == CntW'(MaxFlits - 1))) begin
            pkt_done = 1'b1;
            state_d  = IDLE;
            if (!req_last[grant_q]) begin
              len_err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      flit_cnt_q   <= '0;
      vc_latched_q <= '0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      flit_cnt_q   <= flit_cnt_d;
      vc_latched_q <= vc_latched_d;
      len_err_q    <= len_err_d;
    end
  end

  assign pkt_src = grant_q;
  assign len_err = len_err_q;

  pe_inj_skid #(
    .DataWidth(DataWidth),
    .ViChAddr (ViChAddr)
  ) u_skid (
    .clk_i      (clock),
    .rst_i      (reset),
    .push_i     (push),
    .data_i     (data_arr[grant_q]),
    .sel_i      (push_sel),
    .pop_i      (PE_OutpReady),
    .in_ready_o (skid_in_ready),
    .valid_o    (PE_OutpEn),
    .data_o     (PE_OutpData),
    .sel_o      (PE_OutpSel)
  );

endmodule

// File: tb/tb_pe_inject_arbiter.sv
// Self-checking bench for pe_inject_arbiter: packet table plus round-robin, backpressure and reset sequences.
module tb_pe_inject_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int VW = 1;
  localparam int MF = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid, req_last, req_ready;
  logic [NR*DW-1:0]  req_data;
  logic [NR*VW-1:0]  req_vc;
  logic [DW-1:0]     PE_OutpData;
  logic              PE_OutpEn, PE_OutpReady;
  logic [VW-1:0]     PE_OutpSel;
  logic              pkt_done;
  logic [1:0]        pkt_src;
  logic              len_err;

  always #5 clock = ~clock;

  pe_inject_arbiter #(
    .NumReq   (NR),
    .DataWidth(DW),
    .ViChAddr (VW),
    .MaxFlits (MF)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_vc      (req_vc),
    .req_ready   (req_ready),
    .PE_OutpData (PE_OutpData),
    .PE_OutpEn   (PE_OutpEn),
    .PE_OutpReady(PE_OutpReady),
    .PE_OutpSel  (PE_OutpSel),
    .pkt_done    (pkt_done),
    .pkt_src     (pkt_src),
    .len_err     (len_err)
  );

  typedef struct packed {logic [7:0] data; logic last; logic vc;} flit_t;
  typedef struct packed {logic [7:0] data; logic sel;} exp_t;
  typedef struct {
    int         src;
    int         n;
    logic [7:0] base;
    logic [7:0] step;
    logic       vc0;
    logic       vc1;
    logic       has_last;
    logic       exp_sel;
    logic       exp_err;
  } vec_t;

  flit_t      src_mem [NR][64];
  int         src_head [NR];
  int         src_tail [NR];
  logic [NR-1:0] src_en;
  exp_t       sb_q [$];
  int         done_q [$];
  int         out_cyc [$];
  int         checks = 0, errors = 0, cyc = 0, occ = 0, ready_mode = 0;
  logic       mon_on = 1'b0, stalled_prev = 1'b0, held_sel = 1'b0;
  logic [7:0] held_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    flit_t f;
    for (int i = 0; i < NR; i++) begin
      if (src_en[i] && src_head[i] != src_tail[i]) begin
        f = src_mem[i][src_head[i]];
        req_valid[i] = 1'b1;
        req_last[i]  = f.last;
        req_data[i*DW +: DW] = f.data;
        req_vc[i]    = f.vc;
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*DW +: DW] = '0;
        req_vc[i]    = 1'b0;
      end
    end
  endtask

  task automatic tick();
    logic [NR-1:0] acc;
    logic          pop;
    exp_t          e;
    int            s;
    @(negedge clock);
    cyc++;
    acc = req_valid & req_ready;
    pop = PE_OutpEn && PE_OutpReady;
    if (mon_on) begin
      if (stalled_prev) begin
        chk("stall_data", 32'(PE_OutpData), 32'(held_data));
        chk("stall_sel", 32'(PE_OutpSel), 32'(held_sel));
      end
      chk("en_vs_occupancy", 32'(PE_OutpEn), 32'(occ != 0));
      if (occ == 2) chk("ready_when_full", 32'(req_ready), 0);
      if (pop) begin
        out_cyc.push_back(cyc);
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow: got flit %0h, none expected (cycle %0d)", PE_OutpData, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("out_data", 32'(PE_OutpData), 32'(e.data));
          chk("out_sel", 32'(PE_OutpSel), 32'(e.sel));
        end
      end
      if (pkt_done) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_underflow: got pkt_done src %0d, none expected (cycle %0d)", pkt_src, cyc);
        end else begin
          s = done_q.pop_front();
          chk("pkt_src", 32'(pkt_src), 32'(s));
        end
      end
      occ = occ + ((acc != '0) ? 1 : 0) - (pop ? 1 : 0);
    end
    stalled_prev = mon_on && PE_OutpEn && !PE_OutpReady;
    held_data    = PE_OutpData;
    held_sel     = PE_OutpSel;
    @(posedge clock);
    #1;
    for (int i = 0; i < NR; i++) if (acc[i]) src_head[i]++;
    drive();
    case (ready_mode)
      1:       PE_OutpReady = (cyc % 3 == 0);
      2:       PE_OutpReady = 1'b0;
      default: PE_OutpReady = 1'b1;
    endcase
  endtask

  task automatic add_pkt(input int s, input int n, input logic [7:0] base, input logic [7:0] step,
                         input logic v0, input logic v1, input logic has_last);
    flit_t f;
    for (int k = 0; k < n; k++) begin
      f.data = 8'(base + 8'(k) * step);
      f.vc   = (k == 0) ? v0 : v1;
      f.last = has_last && (k == n - 1);
      src_mem[s][src_tail[s]] = f;
      src_tail[s]++;
    end
  endtask

  task automatic expect_pkt(input int s, input int n, input logic [7:0] base, input logic [7:0] step,
                            input logic sel);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.data = 8'(base + 8'(k) * step);
      e.sel  = sel;
      sb_q.push_back(e);
    end
    done_q.push_back(s);
  endtask

  function automatic bit drained();
    for (int i = 0; i < NR; i++) if (src_head[i] != src_tail[i]) return 1'b0;
    return (sb_q.size() == 0) && (done_q.size() == 0);
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!drained() && n < budget) begin
      tick();
      n++;
    end
    if (!drained()) begin
      checks++; errors++;
      $display("FAIL %s_timeout: %0d flits and %0d packets still pending after %0d cycles",
               name, sb_q.size(), done_q.size(), budget);
      sb_q.delete();
      done_q.delete();
    end
    tick();
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NR; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
    end
    src_en = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs [5];
    int   start, n;

    vecs[0] = '{0,  3, 8'h11, 8'h11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{3,  2, 8'hA0, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{2,  1, 8'h5A, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{0, 16, 8'h80, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1,  5, 8'hE0, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    reset = 1'b1;
    PE_OutpReady = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0; req_vc = '0;
    clear_sources();
    drive();
    repeat (2) tick();
    chk("rst_en", 32'(PE_OutpEn), 0);
    chk("rst_data", 32'(PE_OutpData), 0);
    chk("rst_sel", 32'(PE_OutpSel), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_done", 32'(pkt_done), 0);
    chk("rst_src", 32'(pkt_src), 0);
    chk("rst_len_err", 32'(len_err), 0);
    reset  = 1'b0;
    mon_on = 1'b1;
    occ    = 0;

    // Single packets from the table, full NOC throughput.
    for (int v = 0; v < 5; v++) begin
      out_cyc.delete();
      add_pkt(vecs[v].src, vecs[v].n, vecs[v].base, vecs[v].step, vecs[v].vc0, vecs[v].vc1, vecs[v].has_last);
      expect_pkt(vecs[v].src, vecs[v].n, vecs[v].base, vecs[v].step, vecs[v].exp_sel);
      src_en[vecs[v].src] = 1'b1;
      drive();
      start = cyc + 1;
      wait_idle("table", 60);
      if (out_cyc.size() > 0) begin
        chk("first_flit_latency", 32'(out_cyc[0] - start), 2);
        chk("burst_span", 32'(out_cyc[out_cyc.size()-1] - out_cyc[0]), 32'(vecs[v].n - 1));
      end else begin
        checks++; errors++;
        $display("FAIL table_no_output: got 0 flits, expected %0d", vecs[v].n);
      end
      chk("len_err", 32'(len_err), 32'(vecs[v].exp_err));
      src_en = '0;
    end

    // Atomicity under backpressure: req2 becomes valid once req1 holds the grant.
    ready_mode = 1;
    add_pkt(1, 4, 8'hB0, 8'h01, 1'b1, 1'b0, 1'b1);
    add_pkt(2, 2, 8'hC0, 8'h01, 1'b0, 1'b1, 1'b1);
    expect_pkt(1, 4, 8'hB0, 8'h01, 1'b1);
    expect_pkt(2, 2, 8'hC0, 8'h01, 1'b0);
    src_en[1] = 1'b1;
    drive();
    tick();
    src_en[2] = 1'b1;
    drive();
    wait_idle("backpressure", 100);
    src_en = '0;
    ready_mode = 0;

    // Reset with two flits sitting in the skid.
    ready_mode = 2;
    add_pkt(0, 4, 8'hD0, 8'h01, 1'b1, 1'b1, 1'b1);
    src_en[0] = 1'b1;
    drive();
    n = 0;
    while (occ != 2 && n < 10) begin
      tick();
      n++;
    end
    if (occ != 2) begin
      checks++; errors++;
      $display("FAIL fill_timeout: skid occupancy %0d, expected 2", occ);
    end
    reset = 1'b1;
    tick();
    chk("midrst_en", 32'(PE_OutpEn), 0);
    chk("midrst_ready", 32'(req_ready), 0);
    chk("midrst_len_err", 32'(len_err), 0);
    chk("midrst_done", 32'(pkt_done), 0);
    occ = 0;
    stalled_prev = 1'b0;
    clear_sources();
    ready_mode = 0;
    PE_OutpReady = 1'b1;
    reset = 1'b0;
    drive();

    // Round robin from requester 0, every source continuously requesting.
    out_cyc.delete();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NR; i++) begin
        add_pkt(i, 1, 8'(64 + i * 16 + k), 8'h01, i[0], i[0], 1'b1);
        expect_pkt(i, 1, 8'(64 + i * 16 + k), 8'h01, i[0]);
      end
    src_en = '1;
    drive();
    start = cyc + 1;
    wait_idle("round_robin", 100);
    if (out_cyc.size() == 2 * NR) begin
      chk("rr_first_latency", 32'(out_cyc[0] - start), 2);
      for (int j = 1; j < 2 * NR; j++)
        chk("rr_gap", 32'(out_cyc[j] - out_cyc[j-1]), 2);
    end else begin
      checks++; errors++;
      $display("FAIL rr_count: got %0d flits, expected %0d", out_cyc.size(), 2 * NR);
    end
    chk("rr_len_err", 32'(len_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
